// File: rtl/mac_bist_controller.sv
// rtl/mac_bist_controller.sv - BIST sequencer: applies ROM patterns to a MAC and scores the results
module mac_bist_controller #(
    parameter int NUM_PATTERNS   = 16,
    parameter int START_ADDR     = 1,
    parameter int LAST_ADDR      = 5,
    parameter int A_WIDTH        = 8,
    parameter int W_WIDTH        = 8,
    parameter int P_WIDTH        = 32,
    parameter int MAC_LATENCY    = 2,
    parameter int FAIL_CNT_WIDTH = 8,
    localparam int ADDR_WIDTH    = $clog2(NUM_PATTERNS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [ADDR_WIDTH-1:0]     rom_addr,
    input  logic [A_WIDTH-1:0]        rom_tp_a,
    input  logic [W_WIDTH-1:0]        rom_tp_w,
    input  logic [P_WIDTH-1:0]        rom_tp_p,
    input  logic [P_WIDTH-1:0]        rom_expected_p,
    output logic [A_WIDTH-1:0]        mac_a,
    output logic [W_WIDTH-1:0]        mac_w,
    output logic [P_WIDTH-1:0]        mac_p,
    output logic                      mac_in_valid,
    input  logic [P_WIDTH-1:0]        mac_result,
    input  logic                      mac_out_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    output logic [ADDR_WIDTH-1:0]     first_fail_addr
);

    localparam int WCW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;

    state_t                    state, next_state;
    logic [WCW-1:0]            wait_cnt;
    logic [P_WIDTH-1:0]        exp_q;
    logic                      mismatch;
    logic                      is_last;
    logic [FAIL_CNT_WIDTH-1:0] fail_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = APPLY;
            APPLY:      next_state = WAIT;
            WAIT:       if (wait_cnt == '0) next_state = CHECK;
            CHECK:      next_state = is_last ? DONE : APPLY;
            default:    next_state = IDLE;
        endcase
    end

    // A missing valid counts as a failure just like a wrong value.
    always_comb begin
        mismatch  = !mac_out_valid || (mac_result != exp_q);
        is_last   = (rom_addr == ADDR_WIDTH'(LAST_ADDR));
        fail_next = fail_count;
        if (mismatch && !(&fail_count)) begin
            fail_next = fail_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr        <= '0;
            mac_a           <= '0;
            mac_w           <= '0;
            mac_p           <= '0;
            mac_in_valid    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            wait_cnt        <= '0;
            exp_q           <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rom_addr        <= ADDR_WIDTH'(START_ADDR);
                        fail_count      <= '0;
                        first_fail_addr <= '0;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
                    end
                end
                APPLY: begin
                    mac_a        <= rom_tp_a;
                    mac_w        <= rom_tp_w;
                    mac_p        <= rom_tp_p;
                    exp_q        <= rom_expected_p;
                    mac_in_valid <= 1'b1;
                    wait_cnt     <= WCW'(MAC_LATENCY - 1);
                end
                WAIT: begin
                    mac_in_valid <= 1'b0;
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    fail_count <= fail_next;
                    if (mismatch && fail_count == '0) begin
                        first_fail_addr <= rom_addr;
                    end
                    if (is_last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (fail_next == '0);
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_bist_controller.sv
// tb/tb_mac_bist_controller.sv - directed and randomized bench with a pattern-level reference model
module tb_mac_bist_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  rom_addr;
    logic [7:0]  rom_tp_a, rom_tp_w, mac_a, mac_w;
    logic [31:0] rom_tp_p, rom_expected_p, mac_p, mac_result;
    logic        mac_in_valid, mac_out_valid, busy, done, pass;
    logic [7:0]  fail_count;
    logic [3:0]  first_fail_addr;

    int checks = 0;
    int failures = 0;
    int mode = 0;   // 0 ideal, 1 +1 at addr 3, 2 bit7 stuck-at-0, 3 valid tied low

    int ra[16], rw[16], rp[16], re[16];

    always #5 clk = ~clk;

    assign rom_tp_a       = 8'(ra[rom_addr]);
    assign rom_tp_w       = 8'(rw[rom_addr]);
    assign rom_tp_p       = 32'(rp[rom_addr]);
    assign rom_expected_p = 32'(re[rom_addr]);

    mac_bist_controller dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr),
        .rom_tp_a(rom_tp_a), .rom_tp_w(rom_tp_w), .rom_tp_p(rom_tp_p),
        .rom_expected_p(rom_expected_p), .mac_a(mac_a), .mac_w(mac_w),
        .mac_p(mac_p), .mac_in_valid(mac_in_valid), .mac_result(mac_result),
        .mac_out_valid(mac_out_valid), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_addr(first_fail_addr)
    );

    function automatic int mac_fn(input int addr, input int v, input int m);
        if (m == 1 && addr == 3) return v + 1;
        if (m == 2) return v & 32'hFFFF_FF7F;
        return v;
    endfunction

    // Two-stage MAC under test with optional fault injection.
    logic        s1_v, s2_v;
    logic [31:0] s1_r, s2_r;
    always @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0; s2_v <= 1'b0; s1_r <= '0; s2_r <= '0;
        end else begin
            s1_v <= mac_in_valid;
            s1_r <= 32'(mac_fn(int'(rom_addr),
                    int'($signed(mac_a)) * int'($signed(mac_w)) + int'($signed(mac_p)), mode));
            s2_v <= s1_v;
            s2_r <= s1_r;
        end
    end
    assign mac_result    = s2_r;
    assign mac_out_valid = s2_v && (mode != 3);

    function automatic void model(input int m, output int fc, output int ffa);
        fc = 0;
        ffa = 0;
        for (int a = 1; a <= 5; a++) begin
            int r;
            r = mac_fn(a, ra[a] * rw[a] + rp[a], m);
            if (m == 3 || r != re[a]) begin
                if (fc == 0) ffa = a;
                if (fc < 255) fc++;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {60'd0, rom_addr}, 64'd0);
        check({tag, "_mac"}, {mac_a, mac_w, mac_p, mac_in_valid}, 64'd0);
        check({tag, "_status"}, {busy, done, pass, fail_count, first_fail_addr}, 64'd0);
    endtask

    task automatic load_fixed();
        for (int i = 0; i < 16; i++) begin
            ra[i] = 0; rw[i] = 0; rp[i] = 0; re[i] = 0;
        end
        ra[1] = 5;   rw[1] = 10;  rp[1] = 100;  re[1] = 150;
        ra[2] = -5;  rw[2] = 10;  rp[2] = 100;  re[2] = 50;
        ra[3] = -5;  rw[3] = -10; rp[3] = 100;  re[3] = 150;
        ra[4] = 5;   rw[4] = 10;  rp[4] = -200; re[4] = -150;
        ra[5] = 120; rw[5] = 0;   rp[5] = -50;  re[5] = -50;
    endtask

    task automatic load_random();
        for (int i = 1; i <= 5; i++) begin
            ra[i] = int'($urandom_range(255)) - 128;
            rw[i] = int'($urandom_range(255)) - 128;
            rp[i] = int'($urandom_range(200000)) - 100000;
            re[i] = ra[i] * rw[i] + rp[i];
            if ($urandom_range(3) == 0) re[i] = re[i] ^ (1 << $urandom_range(31));
        end
    endtask

    task automatic run(input string tag, input bit midstart);
        int cyc, pulses, efc, effa;
        model(mode, efc, effa);
        pulses = 0;
        cyc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_started"}, {62'd0, busy, done}, 64'd2);
        if (mac_in_valid) pulses++;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (mac_in_valid) pulses++;
            if (midstart && cyc == 6) start = 1'b1;
            if (midstart && cyc == 7) begin
                start = 1'b0;
                check({tag, "_midstart_busy"}, {63'd0, busy}, 64'd1);
            end
        end
        check({tag, "_done_cycles"}, 64'(cyc), 64'd20);
        check({tag, "_in_valid_pulses"}, 64'(pulses), 64'd5);
        check({tag, "_pass"}, {63'd0, pass}, {63'd0, efc == 0});
        check({tag, "_fail_count"}, 64'(fail_count), 64'(efc));
        check({tag, "_first_fail"}, 64'(first_fail_addr), 64'(effa));
        check({tag, "_final_addr_busy"}, {59'd0, rom_addr, busy}, {59'd0, 4'd5, 1'b0});
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        load_fixed();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        mode = 0; run("ideal", 1'b0);
        mode = 1; run("plus1_addr3", 1'b0);
        check("plus1_first_const", 64'(first_fail_addr), 64'd3);
        mode = 2; run("bit7_stuck", 1'b0);
        check("bit7_count_const", 64'(fail_count), 64'd3);
        mode = 3; run("no_valid_midstart", 1'b1);

        // Abort in WAIT of pattern 3
        mode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(rom_addr == 4'd3 && mac_in_valid) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_wait_p3", 64'(cyc < 100), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("abort");
        @(posedge clk); #1;
        check_all_zero("abort_idle_hold");
        run("after_abort", 1'b0);

        // Faulty run, then rerun from DONE without fault
        mode = 2; run("fault_before_rerun", 1'b0);
        mode = 0; run("rerun", 1'b0);

        for (int k = 0; k < 6; k++) begin
            load_random();
            mode = int'($urandom_range(3));
            run($sformatf("rand%0d_m%0d", k, mode), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_bist_controller.md
Name: mac_bist_controller

Overview:
- Consumer side of the test pattern ROM: sequences ROM addresses, applies each (a, w, p) pattern to the MAC/PE under test, waits the MAC pipeline latency, and compares the MAC result against the ROM's expected_p.
- Accumulates a failure count, records the first failing address, and reports done/pass to the top-level BIST wrapper.
- Sits between the pattern ROM, which is combinational and addressed by this block, and one MAC/PE instance.

Parameters:
- NUM_PATTERNS, 16, ROM depth; ADDR_WIDTH = $clog2(NUM_PATTERNS).
- START_ADDR, 1, first pattern address applied. Address 0 is the all-zero default entry and is skipped by default.
- LAST_ADDR, 5, last pattern address applied. Requires START_ADDR <= LAST_ADDR < NUM_PATTERNS.
- A_WIDTH, 8, activation width (signed).
- W_WIDTH, 8, weight width (signed).
- P_WIDTH, 32, partial-sum and result width (signed).
- MAC_LATENCY, 2, cycles from the mac_in_valid cycle to the valid MAC result. Minimum is 1.
- FAIL_CNT_WIDTH, 8, width of the failure counter.

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, synchronous, active-high reset.
- start, in, 1, one-cycle pulse that begins a run. Honoured only in IDLE or DONE.
- rom_addr, out, ADDR_WIDTH, address to the pattern ROM.
- rom_tp_a, in, A_WIDTH, ROM activation (signed).
- rom_tp_w, in, W_WIDTH, ROM weight (signed).
- rom_tp_p, in, P_WIDTH, ROM partial sum (signed).
- rom_expected_p, in, P_WIDTH, ROM golden result (signed).
- mac_a, out, A_WIDTH, registered activation to the MAC.
- mac_w, out, W_WIDTH, registered weight to the MAC.
- mac_p, out, P_WIDTH, registered partial sum to the MAC.
- mac_in_valid, out, 1, one-cycle strobe marking valid MAC inputs.
- mac_result, in, P_WIDTH, MAC output (signed).
- mac_out_valid, in, 1, MAC output valid.
- busy, out, 1, high while a run is in progress.
- done, out, 1, high in DONE; held until the next start or rst.
- pass, out, 1, valid while done=1; 1 iff fail_count == 0.
- fail_count, out, FAIL_CNT_WIDTH, number of failing patterns; saturates at all-ones.
- first_fail_addr, out, ADDR_WIDTH, address of the first failing pattern; 0 if none.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0, including rom_addr=0, mac_* = 0, mac_in_valid=0, busy=0, done=0, pass=0, fail_count=0 and first_fail_addr=0.
  - rst overrides start, and aborts a run from any state.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE / DONE:
  - On start: rom_addr<=START_ADDR, fail_count<=0, first_fail_addr<=0, done<=0, pass<=0, busy<=1, go to APPLY.
  - start is ignored in APPLY, WAIT and CHECK.
- APPLY (1 cycle):
  - The ROM is combinational, so its outputs are valid this cycle.
  - Register mac_a/w/p <= rom_tp_a/w/p and exp_q <= rom_expected_p.
  - Set mac_in_valid<=1 and wait_cnt<=MAC_LATENCY-1, then go to WAIT.
- WAIT (exactly MAC_LATENCY cycles):
  - mac_in_valid is high only in the first WAIT cycle; it is cleared on the next edge.
  - Decrement wait_cnt; when it is 0, go to CHECK.
  - The CHECK cycle therefore falls exactly MAC_LATENCY cycles after the mac_in_valid cycle.
- CHECK (1 cycle):
  - A pattern fails if mac_out_valid==0 or mac_result != exp_q. The comparison is on all P_WIDTH bits.
  - On failure: fail_count increments, holding at all-ones. If fail_count was 0, first_fail_addr <= rom_addr.
  - If rom_addr == LAST_ADDR: go to DONE, busy<=0, done<=1, pass<=(final fail_count==0). The final fail_count includes this CHECK's result.
  - Otherwise: rom_addr <= rom_addr+1 and go to APPLY.
- Timing:
  - Each pattern takes MAC_LATENCY+2 cycles.
  - done rises (LAST_ADDR-START_ADDR+1)*(MAC_LATENCY+2) cycles after the start-sampling edge.
- No wrap-around: rom_addr never exceeds LAST_ADDR. In DONE, rom_addr holds LAST_ADDR.
- With START_ADDR == LAST_ADDR the run is a single pattern.
- mac_out_valid outside CHECK is ignored.
- A start pulse from DONE clears the previous results and reruns.

Test Plan:
- Ideal MAC model (L=2), ROM entries 1..5 as (5,10,100→150), (-5,10,100→50), (-5,-10,100→150), (5,10,-200→-150), (120,0,-50→-50), start pulse → done rises 20 cycles later, pass=1, fail_count=0, first_fail_addr=0, mac_in_valid pulsed exactly 5 times.
- MAC model adds +1 only at addr 3 → pass=0, fail_count=1, first_fail_addr=3.
- MAC result bit 7 stuck-at-0 → entries 1, 3 and 5 fail (150=0x96, -50=0x...CE); fail_count=3, first_fail_addr=1, pass=0.
- mac_out_valid tied 0 → fail_count=5, first_fail_addr=1, pass=0. Also check that a start pulse in mid-run is ignored: busy stays 1 and the 20-cycle timing is unchanged.
- rst asserted in WAIT of pattern 3 → next cycle all outputs 0 and state IDLE. A fresh start then gives a full 20-cycle run with pass=1.
- Completed run with a fault, then remove the fault and pulse start in DONE → done drops the next cycle; the rerun ends with pass=1, fail_count=0, first_fail_addr=0.
